// File: rtl/serial_rx8_deserializer.sv
// Serial receive deserializer: start bit, DATA_W data bits LSB first, stop bit -> q (valid/ready).
// Define PARITY_CHECK_EN to expect and check an even-parity bit between data and stop.
module serial_rx8_deserializer #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              s_in,
    input  logic              s_valid,
    output logic [DATA_W-1:0] q,
    output logic              q_valid,
    input  logic              q_ready,
    output logic              busy,
    output logic              frame_err,
    output logic              overrun,
    output logic              parity_err
);

    typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              valid_q, valid_d;
    logic              ferr_q, ferr_d;
    logic              ovr_q, ovr_d;
    logic              perr_q, perr_d;
    logic              good_frame;
`ifdef PARITY_CHECK_EN
    logic              par_q, par_d;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            shreg_q <= '0;
            word_q  <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
            perr_q  <= 1'b0;
`ifdef PARITY_CHECK_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            word_q  <= word_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
            perr_q  <= perr_d;
`ifdef PARITY_CHECK_EN
            par_q   <= par_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        word_d     = word_q;
        cnt_d      = cnt_q;
        valid_d    = valid_q;
        ferr_d     = 1'b0;
        ovr_d      = ovr_q;
        perr_d     = 1'b0;
        good_frame = 1'b0;
`ifdef PARITY_CHECK_EN
        par_d      = par_q;
`endif

        if (valid_q && q_ready) begin
            valid_d = 1'b0;
        end

        if (s_valid) begin
            unique case (state_q)
                StIdle: begin
                    if (!s_in) begin
                        state_d = StData;
                        cnt_d   = '0;
                    end
                end
                StData: begin
                    shreg_d[cnt_q] = s_in;
                    cnt_d          = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
`ifdef PARITY_CHECK_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end
                end
`ifdef PARITY_CHECK_EN
                StParity: begin
                    par_d   = s_in;
                    state_d = StStop;
                end
`endif
                StStop: begin
                    state_d = StIdle;
                    // A bad stop bit masks any parity problem.
                    if (!s_in) begin
                        ferr_d = 1'b1;
                    end else begin
`ifdef PARITY_CHECK_EN
                        if (par_q != ^shreg_q) begin
                            perr_d = 1'b1;
                        end else begin
                            good_frame = 1'b1;
                        end
`else
                        good_frame = 1'b1;
`endif
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        // Commit wins over a same-edge handshake; otherwise the pending word blocks it.
        if (good_frame) begin
            if (!valid_q || q_ready) begin
                word_d  = shreg_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    assign q          = word_q;
    assign q_valid    = valid_q;
    assign busy       = (state_q != StIdle);
    assign frame_err  = ferr_q;
    assign overrun    = ovr_q;
    assign parity_err = perr_q;

endmodule

// File: tb/tb_serial_rx8_deserializer.sv
// Self-checking bench for serial_rx8_deserializer: table vectors, corner sequences, random frames.
// Honours PARITY_CHECK_EN the same way the design does.
module tb_serial_rx8_deserializer;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       s_in = 1'b1;
    logic       s_valid = 1'b0;
    logic       q_ready = 1'b0;
    logic [7:0] q;
    logic       q_valid, busy, frame_err, overrun, parity_err;

    int checks = 0;
    int failures = 0;

    // Reference model: what the consumer side should see.
    logic [7:0] exp_q = 8'h00;
    logic       exp_valid = 1'b0;
    logic       exp_ovr = 1'b0;
    logic       exp_ferr = 1'b0;
    logic       exp_perr = 1'b0;

    typedef struct {
        logic       rst;
        logic [7:0] d;
        logic       stop;
        logic       rdy;
        logic [7:0] eq;
        logic       ev;
        logic       eo;
        logic       ef;
    } vec_t;

    vec_t tbl[7];

    serial_rx8_deserializer #(.DATA_W(8), .CNT_W(3)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .s_in      (s_in),
        .s_valid   (s_valid),
        .q         (q),
        .q_valid   (q_valid),
        .q_ready   (q_ready),
        .busy      (busy),
        .frame_err (frame_err),
        .overrun   (overrun),
        .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic cycle(input logic v, input logic b, input logic r);
        s_valid = v;
        s_in    = b;
        q_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input int gapmax, input logic r);
        repeat ($urandom_range(gapmax, 0)) cycle(1'b0, 1'($urandom_range(1, 0)), 1'b0);
        cycle(1'b1, b, r);
    endtask

    task automatic model_reset();
        exp_q     = 8'h00;
        exp_valid = 1'b0;
        exp_ovr   = 1'b0;
    endtask

    task automatic do_reset();
        s_valid = 1'b0;
        q_ready = 1'b0;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        cycle(1'b0, 1'b1, 1'b0);
        model_reset();
    endtask

    // Drives one frame; q_ready is only raised during the stop-bit cycle.
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_good,
                              input logic r, input int gapmax);
        logic [7:0] dv;
        logic       good;
        dv = d;
        send_bit(1'b0, gapmax, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(dv[i], gapmax, 1'b0);
`ifdef PARITY_CHECK_EN
        send_bit(par_good ? ^dv : ~^dv, gapmax, 1'b0);
        good     = stop && par_good;
        exp_perr = stop && !par_good;
`else
        good     = stop;
        exp_perr = 1'b0;
`endif
        exp_ferr = !stop;
        send_bit(stop, gapmax, r);
        if (good) begin
            if (!exp_valid || r) begin
                exp_q     = d;
                exp_valid = 1'b1;
            end else begin
                exp_ovr = 1'b1;
            end
        end else if (exp_valid && r) begin
            exp_valid = 1'b0;
        end
    endtask

    task automatic check_after(input logic [7:0] eq, input logic ev, input logic eo,
                               input logic ef, input logic ep);
        chk("q", 32'(q), 32'(eq));
        chk("q_valid", 32'(q_valid), 32'(ev));
        chk("overrun", 32'(overrun), 32'(eo));
        chk("frame_err", 32'(frame_err), 32'(ef));
        chk("parity_err", 32'(parity_err), 32'(ep));
        chk("busy_idle", 32'(busy), 32'd0);
        cycle(1'b0, 1'b1, 1'b0);
        chk("frame_err_pulse", 32'(frame_err), 32'd0);
        chk("parity_err_pulse", 32'(parity_err), 32'd0);
    endtask

    initial begin
        tbl[0] = '{rst: 1'b1, d: 8'hA5, stop: 1'b1, rdy: 1'b0, eq: 8'hA5, ev: 1'b1, eo: 1'b0, ef: 1'b0};
        tbl[1] = '{rst: 1'b0, d: 8'h3C, stop: 1'b1, rdy: 1'b0, eq: 8'hA5, ev: 1'b1, eo: 1'b1, ef: 1'b0};
        tbl[2] = '{rst: 1'b1, d: 8'hA5, stop: 1'b1, rdy: 1'b0, eq: 8'hA5, ev: 1'b1, eo: 1'b0, ef: 1'b0};
        tbl[3] = '{rst: 1'b0, d: 8'h3C, stop: 1'b1, rdy: 1'b1, eq: 8'h3C, ev: 1'b1, eo: 1'b0, ef: 1'b0};
        tbl[4] = '{rst: 1'b0, d: 8'h5A, stop: 1'b0, rdy: 1'b0, eq: 8'h3C, ev: 1'b1, eo: 1'b0, ef: 1'b1};
        tbl[5] = '{rst: 1'b0, d: 8'h5A, stop: 1'b0, rdy: 1'b1, eq: 8'h3C, ev: 1'b0, eo: 1'b0, ef: 1'b1};
        tbl[6] = '{rst: 1'b0, d: 8'h81, stop: 1'b1, rdy: 1'b0, eq: 8'h81, ev: 1'b1, eo: 1'b0, ef: 1'b0};

        // Asynchronous reset, checked before any clock edge.
        #2 reset_n = 1'b0;
        #1;
        chk("rst_q", 32'(q), 32'd0);
        chk("rst_q_valid", 32'(q_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        chk("rst_parity_err", 32'(parity_err), 32'd0);
        do_reset();

        for (int i = 0; i < 7; i++) begin
            if (tbl[i].rst) do_reset();
            send_frame(tbl[i].d, tbl[i].stop, 1'b1, tbl[i].rdy, 2);
            check_after(tbl[i].eq, tbl[i].ev, tbl[i].eo, tbl[i].ef, 1'b0);
        end

        // Handshake drain, then q_ready with nothing pending.
        cycle(1'b0, 1'b1, 1'b1);
        chk("drain_q_valid", 32'(q_valid), 32'd0);
        cycle(1'b0, 1'b1, 1'b1);
        chk("idle_ready_q_valid", 32'(q_valid), 32'd0);

        // Reset mid-frame after 4 data bits discards the partial frame silently.
        do_reset();
        send_frame(8'hA5, 1'b1, 1'b1, 1'b0, 1);
        check_after(exp_q, exp_valid, exp_ovr, exp_ferr, exp_perr);
        send_bit(1'b0, 1, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1, 1'b0);
        chk("midframe_busy", 32'(busy), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_q_valid", 32'(q_valid), 32'd0);
        chk("midrst_q", 32'(q), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
        send_frame(8'h81, 1'b1, 1'b1, 1'b0, 2);
        check_after(8'h81, 1'b1, 1'b0, 1'b0, 1'b0);

`ifdef PARITY_CHECK_EN
        do_reset();
        send_frame(8'h07, 1'b1, 1'b0, 1'b0, 2);
        check_after(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        send_frame(8'h07, 1'b0, 1'b0, 1'b0, 2);
        check_after(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        send_frame(8'h07, 1'b1, 1'b1, 1'b0, 2);
        check_after(8'h07, 1'b1, 1'b0, 1'b0, 1'b0);
`endif

        // Randomized frames, gaps, idle-line bits and drains against the model.
        do_reset();
        for (int n = 0; n < 40; n++) begin
            repeat ($urandom_range(2, 0)) cycle(1'b1, 1'b1, 1'b0);
            if ($urandom_range(3, 0) == 0) begin
                cycle(1'b0, 1'b1, 1'b1);
                exp_valid = 1'b0;
            end
            send_frame(8'($urandom_range(255, 0)), $urandom_range(9, 0) != 0,
                       $urandom_range(4, 0) != 0, 1'($urandom_range(1, 0)), 3);
            check_after(exp_q, exp_valid, exp_ovr, exp_ferr, exp_perr);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
